// File: rtl/sys_cmd_tx_pkg.sv
// rtl/sys_cmd_tx_pkg.sv - shared opcodes, command encodings and FSM states for sys_cmd_tx
package sys_cmd_tx_pkg;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_GUARD    = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

  typedef struct packed {
    cmd_type_e  ctype;
    logic [3:0] addr;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] fun;
  } cmd_req_t;

endpackage

// File: rtl/sys_cmd_tx_frame_build.sv
// rtl/sys_cmd_tx_frame_build.sv - maps a registered request and byte index to frame byte and lengths
module sys_cmd_tx_frame_build
  import sys_cmd_tx_pkg::*;
#(
  parameter int ALU_RSP_BYTES = 1
) (
  input  cmd_req_t   req_i,
  input  logic [1:0] idx_i,
  output logic [7:0] byte_o,
  output logic [2:0] frame_len_o,
  output logic [1:0] rsp_len_o
);

  localparam logic [1:0] ALU_RSP_LEN = 2'(ALU_RSP_BYTES);

  always_comb begin
    byte_o      = 8'h00;
    frame_len_o = 3'd2;
    rsp_len_o   = 2'd0;
    case (req_i.ctype)
      CMD_RF_WR: begin
        frame_len_o = 3'd3;
        case (idx_i)
          2'd0:    byte_o = OPC_RF_WR;
          2'd1:    byte_o = {4'h0, req_i.addr};
          default: byte_o = req_i.op_a;
        endcase
      end
      CMD_RF_RD: begin
        rsp_len_o = 2'd1;
        byte_o    = (idx_i == 2'd0) ? OPC_RF_RD : {4'h0, req_i.addr};
      end
      CMD_ALU_OP: begin
        frame_len_o = 3'd4;
        rsp_len_o   = ALU_RSP_LEN;
        case (idx_i)
          2'd0:    byte_o = OPC_ALU_OP;
          2'd1:    byte_o = req_i.op_a;
          2'd2:    byte_o = req_i.op_b;
          default: byte_o = {4'h0, req_i.fun};
        endcase
      end
      default: begin
        rsp_len_o = ALU_RSP_LEN;
        byte_o    = (idx_i == 2'd0) ? OPC_ALU_NOP : {4'h0, req_i.fun};
      end
    endcase
  end

endmodule

// File: rtl/sys_cmd_tx.sv
// rtl/sys_cmd_tx.sv - host-side command initiator: serializes one command frame, collects its response
module sys_cmd_tx
  import sys_cmd_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ALU_RSP_BYTES  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [3:0]  CMD_ADDR,
  input  logic [7:0]  CMD_OP_A,
  input  logic [7:0]  CMD_OP_B,
  input  logic [3:0]  CMD_FUN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  output logic [15:0] RSP_DATA,
  output logic        RSP_VALID,
  output logic        RSP_TIMEOUT
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  cmd_req_t    req_q, req_d;
  logic [1:0]  idx_q, idx_d;
  logic        rx_idx_q, rx_idx_d;
  logic [15:0] rx_buf_q, rx_buf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  logic [7:0]  frame_byte;
  logic [2:0]  frame_len;
  logic [1:0]  rsp_len;

  sys_cmd_tx_frame_build #(
    .ALU_RSP_BYTES(ALU_RSP_BYTES)
  ) u_frame_build (
    .req_i      (req_q),
    .idx_i      (idx_q),
    .byte_o     (frame_byte),
    .frame_len_o(frame_len),
    .rsp_len_o  (rsp_len)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    idx_d         = idx_q;
    rx_idx_d      = rx_idx_q;
    rx_buf_d      = rx_buf_q;
    tmo_d         = tmo_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          req_d.ctype = cmd_type_e'(CMD_TYPE);
          req_d.addr  = CMD_ADDR;
          req_d.op_a  = CMD_OP_A;
          req_d.op_b  = CMD_OP_B;
          req_d.fun   = CMD_FUN;
          idx_d       = 2'd0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!TX_BUSY) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if ({1'b0, idx_q} == frame_len - 3'd1) begin
          if (rsp_len == 2'd0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'h0000;
            state_d     = ST_IDLE;
          end else begin
            tmo_d    = '0;
            rx_idx_d = 1'b0;
            rx_buf_d = 16'h0000;
            state_d  = ST_WAIT_RSP;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SEND;
        end
      end
      ST_WAIT_RSP: begin
        // An RX byte takes priority over a simultaneous timeout expiry.
        if (RX_D_VLD) begin
          tmo_d = '0;
          if (rx_idx_q) rx_buf_d[15:8] = RX_P_DATA;
          else          rx_buf_d[7:0]  = RX_P_DATA;
          if ({1'b0, rx_idx_q} == rsp_len - 2'd1) begin
            rsp_data_d  = rx_buf_d;
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            rx_idx_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      idx_q         <= 2'd0;
      rx_idx_q      <= 1'b0;
      rx_buf_q      <= 16'h0000;
      tmo_q         <= '0;
      rsp_data_q    <= 16'h0000;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      idx_q         <= idx_d;
      rx_idx_q      <= rx_idx_d;
      rx_buf_q      <= rx_buf_d;
      tmo_q         <= tmo_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY   = (state_q == ST_IDLE);
  assign TX_D_VLD    = (state_q == ST_SEND);
  assign TX_P_DATA   = TX_D_VLD ? frame_byte : 8'h00;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule
